// File: rtl/mux_scan.sv
// N_CH-channel, W-bit registered multiplexer with manual select and masked auto-scan.
// Optional `last` frame-end output is enabled by defining MUX_SCAN_LAST_EN.
module mux_scan #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N_CH),
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH*W-1:0]   I,
  input  logic [SEL_W-1:0]    S,
  input  logic                mode,
  input  logic                en,
  input  logic [N_CH-1:0]     mask,
  output logic [W-1:0]        Y,
  output logic [SEL_W-1:0]    ch,
  output logic                strobe
`ifdef MUX_SCAN_LAST_EN
  ,
  output logic                last
`endif
);

  typedef enum logic {MAN, SCAN} state_t;

  localparam int CW = 16;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [SEL_W-1:0] ch_nxt, adv_ch;
  logic [W-1:0]     y_nxt;
  logic             strobe_nxt;
  logic             s_ok;
  logic [W-1:0]     chan [N_CH];

  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      chan[k] = I[k*W +: W];
    end
  end

  // Range test by enumeration so power-of-2 builds carry no constant compare.
  always_comb begin
    s_ok = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (S == SEL_W'(k)) s_ok = 1'b1;
    end
  end

  // First unmasked channel above ch, wrapping; falls back to ch itself.
  always_comb begin
    logic             found;
    int unsigned      t;
    logic [SEL_W-1:0] idx;
    found  = 1'b0;
    adv_ch = ch;
    t      = 0;
    idx    = '0;
    for (int unsigned d = 1; d <= N_CH; d++) begin
      t = int'(ch) + d;
      if (t >= N_CH) t = t - N_CH;
      idx = SEL_W'(t);
      if (!found && mask[idx]) begin
        found  = 1'b1;
        adv_ch = idx;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ch_nxt     = ch;
    y_nxt      = chan[ch];
    strobe_nxt = 1'b0;
    case (state)
      MAN: begin
        if (mode) begin
          state_nxt = SCAN;
          cnt_nxt   = '0;
        end else if (s_ok) begin
          ch_nxt = S;
          y_nxt  = chan[S];
        end else begin
          y_nxt = '0;
        end
      end
      SCAN: begin
        if (!mode) begin
          state_nxt = MAN;
          cnt_nxt   = '0;
          if (s_ok) begin
            ch_nxt = S;
            y_nxt  = chan[S];
          end else begin
            y_nxt = '0;
          end
        end else if (mask == '0) begin
          cnt_nxt = '0;
          y_nxt   = '0;
        end else if (en) begin
          if (cnt == CW'(DWELL - 1)) begin
            cnt_nxt    = '0;
            strobe_nxt = 1'b1;
            ch_nxt     = adv_ch;
            y_nxt      = chan[adv_ch];
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = MAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MAN;
      cnt    <= '0;
      ch     <= '0;
      Y      <= '0;
      strobe <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ch     <= ch_nxt;
      Y      <= y_nxt;
      strobe <= strobe_nxt;
    end
  end

`ifdef MUX_SCAN_LAST_EN
  always_ff @(posedge clk) begin
    if (rst) last <= 1'b0;
    else     last <= strobe_nxt && (ch_nxt <= ch);
  end
`endif

endmodule

// File: tb/tb_mux_scan.sv
// Self-checking bench for mux_scan: directed table, hand sequences, random vs. reference model.
module tb_mux_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        en = 1'b1;
  logic [31:0] i8 = '0;
  logic [2:0]  s8 = '0;
  logic [7:0]  mask8 = '0;
  logic [3:0]  y8;
  logic [2:0]  ch8;
  logic        st8;
  logic [11:0] i6 = '0;
  logic [2:0]  s6 = '0;
  logic [5:0]  mask6 = '0;
  logic [1:0]  y6;
  logic [2:0]  ch6;
  logic        st6;
`ifdef MUX_SCAN_LAST_EN
  logic        last8, last6;
`endif

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mux_scan #(.N_CH(8), .W(4), .DWELL(4)) dut8 (
    .clk(clk), .rst(rst), .I(i8), .S(s8), .mode(mode), .en(en), .mask(mask8),
    .Y(y8), .ch(ch8), .strobe(st8)
`ifdef MUX_SCAN_LAST_EN
    , .last(last8)
`endif
  );

  mux_scan #(.N_CH(6), .W(2), .DWELL(1)) dut6 (
    .clk(clk), .rst(rst), .I(i6), .S(s6), .mode(mode), .en(en), .mask(mask6),
    .Y(y6), .ch(ch6), .strobe(st6)
`ifdef MUX_SCAN_LAST_EN
    , .last(last6)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: spec rules applied to plain integers.
  typedef struct {
    bit scan;
    int ch;
    int cnt;
    int y;
    bit st;
    bit lst;
  } mdl_t;

  function automatic int slice(logic [63:0] ibus, int k, int w);
    logic [63:0] t;
    t = ibus >> (k * w);
    return int'(t & ((64'd1 << w) - 64'd1));
  endfunction

  function automatic mdl_t step(mdl_t m, int n, int w, int dwell, bit r, bit md,
                                bit e, int s, logic [63:0] mk, logic [63:0] ibus);
    mdl_t q;
    int   nxt;
    q = m;
    q.st = 0;
    q.lst = 0;
    if (r) begin
      q.scan = 0; q.ch = 0; q.cnt = 0; q.y = 0;
      return q;
    end
    mk = mk & ((64'd1 << n) - 64'd1);
    if (m.scan != md) begin
      q.scan = md;
      q.cnt = 0;
      if (md) q.y = slice(ibus, m.ch, w);
      else if (s < n) begin q.ch = s; q.y = slice(ibus, s, w); end
      else q.y = 0;
    end else if (!m.scan) begin
      if (s < n) begin q.ch = s; q.y = slice(ibus, s, w); end
      else q.y = 0;
    end else if (mk == 0) begin
      q.cnt = 0; q.y = 0;
    end else if (!e) begin
      q.y = slice(ibus, m.ch, w);
    end else if (m.cnt == dwell - 1) begin
      nxt = m.ch;
      for (int d = n; d >= 1; d--)
        if (mk[(m.ch + d) % n]) nxt = (m.ch + d) % n;
      q.cnt = 0; q.st = 1; q.lst = (nxt <= m.ch);
      q.ch = nxt; q.y = slice(ibus, nxt, w);
    end else begin
      q.cnt = m.cnt + 1;
      q.y = slice(ibus, m.ch, w);
    end
    return q;
  endfunction

  typedef struct {
    bit          r, md, e;
    logic [2:0]  s;
    logic [7:0]  mk;
    logic [31:0] i;
    int          ch, y;
    bit          st, lst;
  } vec_t;

  function automatic vec_t v(bit r, bit md, bit e, logic [2:0] s, logic [7:0] mk,
                             logic [31:0] i, int ch, int y, bit st, bit lst);
    vec_t t;
    t.r = r; t.md = md; t.e = e; t.s = s; t.mk = mk; t.i = i;
    t.ch = ch; t.y = y; t.st = st; t.lst = lst;
    return t;
  endfunction

  localparam logic [31:0] IB = 32'h7654_3210;

  task automatic step8(input string nm, input bit r, input bit md, input bit e,
                       input logic [2:0] s, input logic [7:0] mk, input logic [31:0] i,
                       input int ech, input int ey, input bit est, input bit elst);
    rst = r; mode = md; en = e; s8 = s; mask8 = mk; i8 = i;
    @(negedge clk);
    chk({nm, ".ch"}, int'(ch8), ech);
    chk({nm, ".y"}, int'(y8), ey);
    chk({nm, ".strobe"}, int'(st8), int'(est));
`ifdef MUX_SCAN_LAST_EN
    chk({nm, ".last"}, int'(last8), int'(elst));
`endif
  endtask

  task automatic step6(input string nm, input bit r, input bit md, input logic [2:0] s,
                       input logic [5:0] mk, input int ech, input int ey, input bit est,
                       input bit elst);
    rst = r; mode = md; en = 1'b1; s6 = s; mask6 = mk;
    @(negedge clk);
    chk({nm, ".ch"}, int'(ch6), ech);
    chk({nm, ".y"}, int'(y6), ey);
    chk({nm, ".strobe"}, int'(st6), int'(est));
`ifdef MUX_SCAN_LAST_EN
    chk({nm, ".last"}, int'(last6), int'(elst));
`endif
  endtask

  initial begin
    vec_t tbl[$];
    mdl_t m8, m6;
    int   nc;

    // Reset, manual select, masked scan with wrap, mode switch, mode-vs-dwell-end.
    tbl.push_back(v(1, 0, 1, 5, 8'hA4, 32'h76A4_3210, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 1, 5, 8'hA4, 32'h76A4_3210, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 5, 8'hA4, 32'h76A4_3210, 5, 10, 0, 0));
    tbl.push_back(v(0, 0, 1, 5, 8'hA4, 32'h7634_3210, 5, 3, 0, 0));
    tbl.push_back(v(0, 0, 1, 2, 8'hA4, IB, 2, 2, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 8'hA4, IB, 2, 2, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 1, 1, 0, 8'hA4, IB, 2, 2, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 8'hA4, IB, 5, 5, 1, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 1, 1, 0, 8'hA4, IB, 5, 5, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 8'hA4, IB, 7, 7, 1, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 1, 1, 0, 8'hA4, IB, 7, 7, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 8'hA4, IB, 2, 2, 1, 1));
    tbl.push_back(v(0, 0, 1, 1, 8'hA4, IB, 1, 1, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(v(0, 1, 1, 1, 8'hA4, IB, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 1, 6, 8'hA4, IB, 6, 6, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 8'hFF, IB, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 8'hFF, IB, 0, 0, 0, 0));
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 4; k++)
        tbl.push_back(v(0, 1, 1, 0, 8'hFF, IB, (k == 3) ? (c + 1) % 8 : c,
                        (k == 3) ? (c + 1) % 8 : c, k == 3, k == 3 && c == 7));

    for (int t = 0; t < tbl.size(); t++)
      step8($sformatf("tbl%0d", t), tbl[t].r, tbl[t].md, tbl[t].e, tbl[t].s, tbl[t].mk,
            tbl[t].i, tbl[t].ch, tbl[t].y, tbl[t].st, tbl[t].lst);

    // Enable pause at counter=2 on ch 3.
    step8("pz_rst", 1, 0, 1, 3, 8'hFF, IB, 0, 0, 0, 0);
    step8("pz_man", 0, 0, 1, 3, 8'hFF, IB, 3, 3, 0, 0);
    for (int k = 0; k < 3; k++) step8("pz_run", 0, 1, 1, 3, 8'hFF, IB, 3, 3, 0, 0);
    for (int k = 0; k < 10; k++) step8("pz_hold", 0, 1, 0, 3, 8'hFF, IB, 3, 3, 0, 0);
    step8("pz_res1", 0, 1, 1, 3, 8'hFF, IB, 3, 3, 0, 0);
    step8("pz_adv", 0, 1, 1, 3, 8'hFF, IB, 4, 4, 1, 0);

    // Mask goes to zero mid-dwell, then returns with the counter restarted.
    step8("mz_run", 0, 1, 1, 0, 8'hFF, IB, 4, 4, 0, 0);
    for (int k = 0; k < 5; k++) step8("mz_zero", 0, 1, 1, 0, 8'h00, IB, 4, 0, 0, 0);
    for (int k = 0; k < 3; k++) step8("mz_back", 0, 1, 1, 0, 8'hFF, IB, 4, 4, 0, 0);
    step8("mz_adv", 0, 1, 1, 0, 8'hFF, IB, 5, 5, 1, 0);

    // Reset mid-dwell: returns to MAN, so re-entry to SCAN costs one extra edge.
    step8("rs_run", 0, 1, 1, 0, 8'hFF, IB, 5, 5, 0, 0);
    step8("rs_rst", 1, 1, 1, 0, 8'hFF, IB, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step8("rs_wait", 0, 1, 1, 0, 8'hFF, IB, 0, 0, 0, 0);
    step8("rs_adv", 0, 1, 1, 0, 8'hFF, IB, 1, 1, 1, 0);

    // Six channels: out-of-range select, DWELL=1 continuous strobe, single-channel wrap.
    i6 = 12'hE4B;
    step6("n6_rst", 1, 0, 4, 6'h3F, 0, 0, 0, 0);
    step6("n6_s4", 0, 0, 4, 6'h3F, 4, slice(64'(i6), 4, 2), 0, 0);
    step6("n6_s7", 0, 0, 7, 6'h3F, 4, 0, 0, 0);
    step6("n6_s6", 0, 0, 6, 6'h3F, 4, 0, 0, 0);
    step6("n6_ent", 0, 1, 6, 6'h3F, 4, slice(64'(i6), 4, 2), 0, 0);
    step6("n6_a5", 0, 1, 6, 6'h3F, 5, slice(64'(i6), 5, 2), 1, 0);
    step6("n6_a0", 0, 1, 6, 6'h3F, 0, slice(64'(i6), 0, 2), 1, 1);
    step6("n6_a1", 0, 1, 6, 6'h3F, 1, slice(64'(i6), 1, 2), 1, 0);
    step6("n6_one", 0, 1, 6, 6'h02, 1, slice(64'(i6), 1, 2), 1, 1);

    // Random traffic on both instances against the reference model.
    m8 = '{0, 0, 0, 0, 0, 0};
    m6 = '{0, 0, 0, 0, 0, 0};
    rst = 1'b1;
    m8 = step(m8, 8, 4, 4, 1, 0, 0, 0, 0, 0);
    m6 = step(m6, 6, 2, 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      chk("rnd8.ch", int'(ch8), m8.ch);
      chk("rnd8.y", int'(y8), m8.y);
      chk("rnd8.strobe", int'(st8), int'(m8.st));
      chk("rnd6.ch", int'(ch6), m6.ch);
      chk("rnd6.y", int'(y6), m6.y);
      chk("rnd6.strobe", int'(st6), int'(m6.st));
`ifdef MUX_SCAN_LAST_EN
      chk("rnd8.last", int'(last8), int'(m8.lst));
      chk("rnd6.last", int'(last6), int'(m6.lst));
`endif
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      en = ($urandom_range(0, 7) != 0);
      i8 = $urandom;
      i6 = 12'($urandom);
      s8 = 3'($urandom);
      s6 = 3'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        nc = $urandom_range(0, 3);
        mask8 = (nc == 0) ? 8'h00 : (nc == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
        mask6 = (nc == 0) ? 6'h00 : (nc == 1) ? 6'(1 << $urandom_range(0, 5)) : 6'($urandom);
      end
      m8 = step(m8, 8, 4, 4, rst, mode, en, int'(s8), 64'(mask8), 64'(i8));
      m6 = step(m6, 6, 2, 1, rst, mode, en, int'(s6), 64'(mask6), 64'(i6));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
Parametrised N-channel, W-bit registered multiplexer with two modes.
- Manual mode: selects a channel by index.
- Auto-scan mode: steps through enabled channels, holding each for a programmable dwell period.
The block sits between multi-source data (switch banks, sensor lines) and single-consumer logic such as a display driver or serial sender. It supersedes the combinational 8:1 single-bit selector.

Parameters:
N_CH, 8, number of input channels (2..64)
W, 1, bit width of each channel
SEL_W, $clog2(N_CH), width of select and channel-index ports
DWELL, 4, clock cycles spent on each channel in scan mode (1..65535)

Ports:
clk     input   1          system clock, rising edge
rst     input   1          synchronous active-high reset
I       input   N_CH*W     packed channel data; channel k = I[k*W +: W]
S       input   SEL_W      manual channel select
mode    input   1          0 = manual, 1 = auto-scan
en      input   1          scan enable; gates the dwell counter only
mask    input   N_CH       scan include mask; bit k = 1 means channel k is visited
Y       output  W          registered selected data
ch      output  SEL_W      channel index currently driving Y
strobe  output  1          one-cycle pulse when a dwell period completes in scan mode

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: Y=0, ch=0, strobe=0, dwell counter=0, state=MAN.
  - Reset asserted mid-scan aborts the scan immediately on that edge.
- Registers: all outputs are registered. Y(t+1) = slice of I(t) at ch(t+1), so Y and ch are always consistent.
- FSM states: MAN, SCAN.
  - MAN -> SCAN when mode=1. Counter cleared; ch retained as the starting channel.
  - SCAN -> MAN when mode=0. Counter cleared; ch <= S on the same edge.
- MAN state:
  - Each cycle, ch <= S if S < N_CH.
  - If S >= N_CH (non-power-of-2 N_CH only): ch holds and Y <= 0.
  - strobe = 0 always.
- SCAN state, en=1:
  - Counter increments 0..DWELL-1.
  - At DWELL-1: counter returns to 0, strobe=1 for one cycle, and ch advances to the next index above ch with mask=1.
  - The search wraps from N_CH-1 to 0 and is completed in one cycle (combinational priority search).
- SCAN state, en=0: counter and ch frozen; Y keeps tracking live I at ch; strobe=0.
- Mask rules:
  - mask may change at any time and takes effect at the next advance.
  - If the current ch is masked, it still finishes its dwell and then advances.
  - If only the current ch is unmasked, ch stays put and strobe still pulses.
  - If mask == 0 in SCAN: ch holds, Y <= 0, strobe=0, counter frozen at 0.
- DWELL=1: ch advances every cycle and strobe is high continuously while scanning.
- mode change and the dwell-end cycle coinciding: the mode change wins; no strobe.

Optional Feature:
MUX_SCAN_LAST_EN
- Defined: adds output port `last` (1 bit, reset 0). It pulses together with strobe when the advance wraps, i.e. the new ch is <= the old ch, marking the end of a scan frame. With a single unmasked channel, `last` pulses on every strobe.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset and manual select (N_CH=8, W=4): rst=1 for 2 cycles -> Y=0, ch=0, strobe=0. Then mode=0, S=5, I[23:20]=4'hA -> next edge ch=5, Y=4'hA. Change I[23:20] to 4'h3 -> Y=4'h3 one cycle later.
- Full scan: mode=1, en=1, mask=8'hFF, DWELL=4, start at ch=0 -> ch sequence 0,1,..,7,0 with 4 cycles per channel; strobe high on cycles 4, 8, 12, ...; with MUX_SCAN_LAST_EN, `last` pulses on the 7->0 advance only.
- Masked scan: mask=8'b1010_0100 from ch=2 -> ch sequence 2,5,7,2; mask changed to 0 mid-dwell -> ch holds, Y=0, no strobe until mask is nonzero again.
- Enable pause: en deasserted for 10 cycles at counter=2 on ch=3 -> ch stays 3, no strobe; after en reasserts, advance occurs exactly 2 cycles later.
- Mode switch and reset: in SCAN at ch=6, set mode=0, S=1 -> next edge ch=1, strobe=0. Return to SCAN and assert rst mid-dwell -> next edge ch=0, Y=0, counter=0, state=MAN.
- Out-of-range select (N_CH=6): S=7 in MAN -> ch holds its previous value, Y=0.
